// File: rtl/normal_random_pkg.sv
// Shared constants, FSM state type and term extraction for the CLT Gaussian source.
package normal_random_pkg;

  localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  // Flipping bit 31 then arithmetic-shifting yields the MSB-inverted top u_w bits, sign-extended.
  function automatic logic signed [31:0] term_of(input logic [31:0] lfsr, input int u_w);
    logic signed [31:0] flipped;
    flipped = $signed(lfsr ^ 32'h8000_0000);
    return flipped >>> (32 - u_w);
  endfunction

endpackage

// File: rtl/lfsr_galois32.sv
// 32-bit right-shifting Galois LFSR with synchronous load (priority) and step enable.
module lfsr_galois32
  import normal_random_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (step) begin
      q_d = q_q[0] ? ((q_q >> 1) ^ LFSR_MASK) : (q_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= SEED;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/normal_random_clt.sv
// Gaussian noise source: sums 2^LOG2_SUM zero-centred LFSR uniforms per sample,
// with a uniform-bypass mode and a valid/ready output that stalls the LFSR.
module normal_random_clt
  import normal_random_pkg::*;
#(
  parameter int          OUT_W        = 16,
  parameter int          LOG2_SUM     = 4,
  parameter logic [31:0] SEED_DEFAULT = DEFAULT_SEED
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seed_we,
  input  logic [31:0]             seed,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] number
);

  localparam int                CNT_W    = (LOG2_SUM == 0) ? 1 : LOG2_SUM;
  localparam int                N        = 1 << LOG2_SUM;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

  state_e                  state_q, state_d;
  logic signed [OUT_W-1:0] acc_q, acc_d, number_q, number_d;
  logic signed [OUT_W-1:0] term, sum;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mode_q, mode_d, out_valid_q, out_valid_d;
  logic                    lfsr_load, lfsr_step, last_term, slot_free;
  logic [31:0]             lfsr_q, lfsr_seed;

  assign lfsr_seed = (seed == 32'd0) ? SEED_DEFAULT : seed;

  lfsr_galois32 #(.SEED(SEED_DEFAULT)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_seed),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  // Uniform mode uses the full output width per term; normal mode leaves LOG2_SUM bits of headroom.
  assign term      = OUT_W'(term_of(lfsr_q, mode_q ? OUT_W : OUT_W - LOG2_SUM));
  assign sum       = acc_q + term;
  assign last_term = mode_q || (cnt_q == CNT_LAST);
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    number_d    = number_q;
    out_valid_d = out_valid_q && !out_ready;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    if (seed_we) begin
      lfsr_load = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
      state_d   = enable ? ACCUM : IDLE;
      if (enable) mode_d = mode;
    end else begin
      case (state_q)
        IDLE: begin
          acc_d = '0;
          cnt_d = '0;
          if (enable) begin
            state_d = ACCUM;
            mode_d  = mode;
          end
        end
        ACCUM: begin
          lfsr_step = 1'b1;
          if (!last_term) begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (slot_free) begin
            number_d    = sum;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = enable ? ACCUM : IDLE;
            if (enable) mode_d = mode;
          end else begin
            acc_d   = sum;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            number_d    = acc_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = enable ? ACCUM : IDLE;
            if (enable) mode_d = mode;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      number_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      number_q    <= number_d;
    end
  end

  assign out_valid = out_valid_q;
  assign number    = number_q;

endmodule

// File: tb/tb_normal_random_clt.sv
// Directed bench for normal_random_clt; a second lfsr_galois32 on its own clock is the reference.
module tb_normal_random_clt;
  import normal_random_pkg::*;

  localparam int NS = 2000;
  localparam int NB = 40;

  logic clk = 1'b0, rst = 1'b0, seed_we = 1'b0, enable = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [31:0] seed = 32'd0;
  logic out_valid;
  logic signed [15:0] number;

  logic ref_clk = 1'b0, ref_rst = 1'b1, ref_load = 1'b0, ref_step = 1'b0;
  logic [31:0] ref_val = 32'd0, ref_q;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit cap_en = 1'b0;
  logic signed [15:0] got[$];
  int got_cyc[$];

  normal_random_clt #(.OUT_W(16), .LOG2_SUM(4), .SEED_DEFAULT(32'hACE1_2468)) dut (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed), .enable(enable), .mode(mode),
    .out_ready(out_ready), .out_valid(out_valid), .number(number)
  );

  lfsr_galois32 #(.SEED(32'hACE1_2468)) u_ref (
    .clk(ref_clk), .rst(ref_rst), .load(ref_load), .load_val(ref_val), .step(ref_step), .q(ref_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_en && out_valid && out_ready) begin
      got.push_back(number);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d required finish", n_tests);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, expv, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ref_pulse();
    ref_clk = 1'b1; #1;
    ref_clk = 1'b0; #1;
  endtask

  task automatic ref_seed(input logic [31:0] v);
    ref_load = 1'b1;
    ref_val  = v;
    ref_pulse();
    ref_load = 1'b0;
  endtask

  // One normal-mode sample: 16 terms of 12 bits, MSB inverted, sign-extended and summed.
  task automatic ref_sample(output logic signed [15:0] s);
    int a;
    logic signed [11:0] t;
    a = 0;
    ref_step = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t = {~ref_q[31], ref_q[30:20]};
      a += int'(t);
      ref_pulse();
    end
    ref_step = 1'b0;
    s = a[15:0];
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k;
    k = 0;
    while (!out_valid && k < max) begin
      tick();
      k++;
    end
    check_val(tag, 32'(out_valid), 32'sd1);
  endtask

  task automatic wait_got(input string tag, input int n, input int max);
    int k;
    k = 0;
    while (got.size() < n && k < max) begin
      tick();
      k++;
    end
    check_val(tag, 32'(got.size() >= n), 32'sd1);
  endtask

  initial begin
    logic signed [15:0] e, e0, e1, ea, eb, ec;
    logic [31:0] exp_lfsr;
    int seen, lim, k;
    longint total;
    int mn, mx;
    real mean;

    // Reset
    #12;
    check_val("rst_valid_in", 32'(out_valid), 32'sd0);
    check_val("rst_number_in", 32'(number), 32'sd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_val("rst_lfsr", dut.u_lfsr.q, 32'hACE1_2468);
    check_val("rst_state", 32'(dut.state_q), 32'(IDLE));
    seen = 0;
    repeat (100) begin
      tick();
      if (out_valid) seen++;
    end
    check_val("rst_idle_no_sample", seen, 0);
    check_val("rst_number_after", 32'(number), 32'sd0);

    // Uniform mode from seed 1
    seed_we = 1'b1; seed = 32'h0000_0001; mode = 1'b1; enable = 1'b1; out_ready = 1'b1;
    tick();
    seed_we = 1'b0;
    tick();
    check_val("uni_valid0", 32'(out_valid), 32'sd1);
    check_val("uni_sample0", 32'(number), -32'sd32768);
    tick();
    check_val("uni_valid1", 32'(out_valid), 32'sd1);
    check_val("uni_sample1", 32'(number), 32'sd32);
    enable = 1'b0;
    tick(3);
    check_val("uni_stop_valid", 32'(out_valid), 32'sd0);
    check_val("uni_stop_state", 32'(dut.state_q), 32'(IDLE));

    // Zero seed falls back to the default seed
    seed_we = 1'b1; seed = 32'd0; mode = 1'b1; enable = 1'b1;
    tick();
    seed_we = 1'b0;
    check_val("zs_lfsr", dut.u_lfsr.q, 32'hACE1_2468);
    tick();
    check_val("zs_sample", 32'(number), 32'sd11489);
    enable = 1'b0;
    tick(3);

    // Normal mode, continuous consumption
    got.delete(); got_cyc.delete();
    cap_en = 1'b1;
    mode = 1'b0; seed = 32'h1234_5678; seed_we = 1'b1; enable = 1'b1; out_ready = 1'b1;
    tick();
    seed_we = 1'b0;
    wait_got("norm_count", NS, NS * 16 + 100);
    enable = 1'b0;
    tick(40);
    cap_en = 1'b0;
    lim = (got.size() < NS) ? got.size() : NS;
    ref_seed(32'h1234_5678);
    total = 0; mn = 32767; mx = -32768;
    for (int i = 0; i < lim; i++) begin
      ref_sample(e);
      check_val("norm_sample", 32'(got[i]), 32'(e));
      if (i > 0) check_val("norm_period", got_cyc[i] - got_cyc[i-1], 16);
      total += longint'(got[i]);
      if (int'(got[i]) < mn) mn = int'(got[i]);
      if (int'(got[i]) > mx) mx = int'(got[i]);
    end
    mean = (lim > 0) ? real'(total) / real'(lim) : 1.0e9;
    check_val("norm_mean_bound", 32'((mean < 480.0) && (mean > -480.0)), 32'sd1);
    check_val("norm_min_bound", 32'(mn >= -32768), 32'sd1);
    check_val("norm_max_bound", 32'(mx <= 32752), 32'sd1);
    tick();

    // Back-pressure: stall, then random ready
    ref_seed(32'h1234_5678);
    ref_sample(e0);
    ref_sample(e1);
    exp_lfsr = ref_q;
    tick();
    got.delete(); got_cyc.delete();
    cap_en = 1'b1;
    seed = 32'h1234_5678; seed_we = 1'b1; enable = 1'b1; mode = 1'b0; out_ready = 1'b0;
    tick();
    seed_we = 1'b0;
    wait_valid("bp_first_valid", 40);
    check_val("bp_first_sample", 32'(number), 32'(e0));
    tick(50);
    check_val("bp_number_stable", 32'(number), 32'(e0));
    check_val("bp_state_hold", 32'(dut.state_q), 32'(HOLD));
    check_val("bp_lfsr_frozen", dut.u_lfsr.q, exp_lfsr);
    check_val("bp_acc_second", 32'(dut.acc_q), 32'(e1));
    k = 0;
    while (got.size() < NB && k < 4000) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    check_val("bp_count", 32'(got.size() >= NB), 32'sd1);
    enable = 1'b0; out_ready = 1'b1;
    tick(40);
    cap_en = 1'b0;
    lim = (got.size() < NB) ? got.size() : NB;
    ref_seed(32'h1234_5678);
    for (int i = 0; i < lim; i++) begin
      ref_sample(e);
      check_val("bp_sample", 32'(got[i]), 32'(e));
    end
    tick();

    // Seed write during ACCUM with a pending sample
    ref_seed(32'h1234_5678);
    ref_sample(ea);
    ref_seed(32'hDEAD_BEEF);
    ref_sample(eb);
    tick();
    got.delete(); got_cyc.delete();
    cap_en = 1'b1;
    seed = 32'h1234_5678; seed_we = 1'b1; enable = 1'b1; mode = 1'b0; out_ready = 1'b0;
    tick();
    seed_we = 1'b0;
    wait_valid("sw_first_valid", 40);
    tick(3);
    check_val("sw_state_accum", 32'(dut.state_q), 32'(ACCUM));
    seed = 32'hDEAD_BEEF; seed_we = 1'b1;
    tick();
    seed_we = 1'b0;
    check_val("sw_pending_valid", 32'(out_valid), 32'sd1);
    check_val("sw_pending_number", 32'(number), 32'(ea));
    out_ready = 1'b1;
    wait_got("sw_count", 2, 60);
    enable = 1'b0;
    tick(40);
    cap_en = 1'b0;
    if (got.size() >= 2) begin
      check_val("sw_sample_old", 32'(got[0]), 32'(ea));
      check_val("sw_sample_new", 32'(got[1]), 32'(eb));
    end

    // Enable dropped mid-sample
    ref_seed(32'h0BAD_F00D);
    ref_sample(ec);
    tick();
    got.delete(); got_cyc.delete();
    cap_en = 1'b1;
    seed = 32'h0BAD_F00D; seed_we = 1'b1; enable = 1'b1; mode = 1'b0; out_ready = 1'b1;
    tick();
    seed_we = 1'b0;
    k = 0;
    while (int'(dut.cnt_q) != 5 && k < 40) begin
      tick();
      k++;
    end
    check_val("en_reach_cnt5", 32'(dut.cnt_q), 32'sd5);
    enable = 1'b0;
    tick(60);
    cap_en = 1'b0;
    check_val("en_one_sample", got.size(), 1);
    if (got.size() >= 1) check_val("en_sample", 32'(got[0]), 32'(ec));
    check_val("en_state_idle", 32'(dut.state_q), 32'(IDLE));

    // Asynchronous reset in the middle of accumulation
    seed = 32'h1234_5678; seed_we = 1'b1; enable = 1'b1; mode = 1'b0; out_ready = 1'b0;
    tick();
    seed_we = 1'b0;
    wait_valid("ar_first_valid", 40);
    tick(4);
    #2 rst = 1'b0;
    #1;
    check_val("ar_valid", 32'(out_valid), 32'sd0);
    check_val("ar_number", 32'(number), 32'sd0);
    check_val("ar_state", 32'(dut.state_q), 32'(IDLE));
    check_val("ar_lfsr", dut.u_lfsr.q, 32'hACE1_2468);
    check_val("ar_acc", 32'(dut.acc_q), 32'sd0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    check_val("ar_after_valid", 32'(out_valid), 32'sd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
